// File: rtl/brick_pkg.sv
// Shared brick-game definitions: field geometry, ball direction encodings
// (also used by ball_movement) and the brick_field state encoding.
package brick_pkg;

  localparam int FIELD_ROWS = 12;
  localparam int FIELD_COLS = 16;
  localparam int PADDLE_ROW = 11;
  localparam int MAP_W      = FIELD_ROWS * FIELD_COLS;

  typedef enum logic [1:0] {
    UP_RIGHT   = 2'b00,
    UP_LEFT    = 2'b01,
    DOWN_RIGHT = 2'b10,
    DOWN_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2,
    S_WIN  = 2'd3
  } state_t;

endpackage

// File: rtl/brick_hit_detect.sv
// Combinational collision check: forms the vertical, horizontal and diagonal
// neighbour cells for a ball step and builds the brick clear mask and count.
module brick_hit_detect
  import brick_pkg::*;
(
  input  logic [MAP_W-1:0] bricks,
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  input  logic [1:0]       dir,
  output logic [MAP_W-1:0] clear_mask,
  output logic [1:0]       n
);

  localparam logic signed [5:0] LAST_BRICK_ROW = 6'(PADDLE_ROW - 1);
  localparam logic signed [5:0] LAST_COL       = 6'(FIELD_COLS - 1);

  logic signed [5:0] v_row;
  logic signed [5:0] h_col;
  logic              v_ok, h_ok, d_ok;
  logic              v_hit, h_hit, d_hit;
  logic [7:0]        v_idx, h_idx, d_idx;

  always_comb begin
    // Column convention follows the ball: RIGHT moves toward column 0.
    v_row = $signed({2'b00, row}) + (dir[1] ? 6'sd1 : -6'sd1);
    h_col = $signed({2'b00, col}) + (dir[0] ? 6'sd1 : -6'sd1);

    v_ok = (v_row >= 6'sd0) && (v_row <= LAST_BRICK_ROW);
    h_ok = (h_col >= 6'sd0) && (h_col <= LAST_COL) && ({2'b00, row} <= LAST_BRICK_ROW);
    d_ok = v_ok && (h_col >= 6'sd0) && (h_col <= LAST_COL);

    v_idx = {v_row[3:0], col};
    h_idx = {row, h_col[3:0]};
    d_idx = {v_row[3:0], h_col[3:0]};

    v_hit = v_ok && bricks[v_idx];
    h_hit = h_ok && bricks[h_idx];
    d_hit = d_ok && bricks[d_idx];

    clear_mask = '0;
    n          = 2'd0;
    if (v_hit || h_hit) begin
      if (v_hit) clear_mask[v_idx] = 1'b1;
      if (h_hit) clear_mask[h_idx] = 1'b1;
      n = {1'b0, v_hit} + {1'b0, h_hit};
    end else if (d_hit) begin
      clear_mask[d_idx] = 1'b1;
      n = 2'd1;
    end
  end

endmodule

// File: rtl/brick_field.sv
// Playfield occupancy map and game-state FSM for the brick game.
// Optional score counter enabled by defining BRICK_FIELD_SCORE_EN.
module brick_field
  import brick_pkg::*;
#(
  parameter int BRICK_ROWS = 4,
  parameter int PADDLE_W   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic [3:0]       Ball_rowIndex,
  input  logic [3:0]       Ball_colIndex,
  input  logic [1:0]       Ball_direction,
  input  logic [3:0]       paddle_col,
  input  logic             restart,
  output logic [MAP_W-1:0] data,
  output logic             IsGameOver,
  output logic             game_lost,
  output logic             game_won,
  output logic [7:0]       bricks_left,
  output logic [7:0]       score
);

  state_t           state;
  logic [3:0]       load_row;
  logic [MAP_W-1:0] bricks;
  logic [MAP_W-1:0] paddle_mask;
  logic [MAP_W-1:0] clear_mask;
  logic [1:0]       n;
  logic [7:0]       left_next;
  logic             lose;
  logic             play_step;
  logic             load_done;

  brick_hit_detect u_hit (
    .bricks     (bricks),
    .row        (Ball_rowIndex),
    .col        (Ball_colIndex),
    .dir        (Ball_direction),
    .clear_mask (clear_mask),
    .n          (n)
  );

  always_comb begin
    paddle_mask = '0;
    for (int c = 0; c < FIELD_COLS; c++) begin
      if (c >= int'(paddle_col) && c < int'(paddle_col) + PADDLE_W)
        paddle_mask[PADDLE_ROW*FIELD_COLS + c] = 1'b1;
    end
    data      = bricks | paddle_mask;
    left_next = bricks_left - {6'd0, n};
    lose      = (Ball_rowIndex == 4'(PADDLE_ROW));
    play_step = step && (state == S_PLAY);
    load_done = (state == S_LOAD) && (load_row == 4'(FIELD_ROWS - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_LOAD;
      load_row    <= 4'd0;
      bricks      <= '0;
      bricks_left <= 8'd0;
      IsGameOver  <= 1'b1;
      game_lost   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          bricks[{load_row, 4'd0} +: FIELD_COLS] <=
            (int'(load_row) < BRICK_ROWS) ? {FIELD_COLS{1'b1}} : {FIELD_COLS{1'b0}};
          if (load_done) begin
            state       <= S_PLAY;
            bricks_left <= 8'(BRICK_ROWS * FIELD_COLS);
            IsGameOver  <= 1'b0;
          end else begin
            load_row <= load_row + 4'd1;
          end
        end
        S_PLAY: begin
          if (step) begin
            // A ball in the paddle row slipped through a gap: loss beats any clear.
            if (lose) begin
              state      <= S_OVER;
              IsGameOver <= 1'b1;
              game_lost  <= 1'b1;
            end else begin
              bricks      <= bricks & ~clear_mask;
              bricks_left <= left_next;
              if (left_next == 8'd0) begin
                state      <= S_WIN;
                IsGameOver <= 1'b1;
                game_won   <= 1'b1;
              end
            end
          end
        end
        S_OVER, S_WIN: begin
          if (restart) begin
            state     <= S_LOAD;
            load_row  <= 4'd0;
            game_lost <= 1'b0;
            game_won  <= 1'b0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

`ifdef BRICK_FIELD_SCORE_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset || load_done) begin
      score <= 8'd0;
    end else if (play_step && !lose) begin
      score <= sat_add(score, n);
    end
  end
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_brick_field.sv
// Randomized scoreboard bench for brick_field against a cell-array game model.
module tb_brick_field;
  import brick_pkg::*;

  localparam int BRICK_ROWS = 4;
  localparam int PADDLE_W   = 3;
  localparam int M_LOAD = 0, M_PLAY = 1, M_OVER = 2, M_WIN = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         step = 1'b0;
  logic         restart = 1'b0;
  logic [3:0]   brow = 4'd0, bcol = 4'd0, pcol = 4'd0;
  logic [1:0]   bdir = 2'd0;
  logic [191:0] data;
  logic         IsGameOver, game_lost, game_won;
  logic [7:0]   bricks_left, score;

  always #5 clock = ~clock;

  brick_field #(.BRICK_ROWS(BRICK_ROWS), .PADDLE_W(PADDLE_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .step           (step),
    .Ball_rowIndex  (brow),
    .Ball_colIndex  (bcol),
    .Ball_direction (bdir),
    .paddle_col     (pcol),
    .restart        (restart),
    .data           (data),
    .IsGameOver     (IsGameOver),
    .game_lost      (game_lost),
    .game_won       (game_won),
    .bricks_left    (bricks_left),
    .score          (score)
  );

  typedef struct {
    logic [191:0] data;
    logic [2:0]   flags;
    logic [7:0]   left;
    logic [7:0]   sc;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference game model: one bit per cell plus plain integer counters.
  bit   map [12][16];
  int   m_state = M_LOAD;
  int   m_row = 0;
  int   m_left = 0;
  int   m_score = 0;
  bit   armed = 1'b0;

  function automatic bit brick_at(int r, int c);
    if (r < 0 || r > 10 || c < 0 || c > 15) return 1'b0;
    return map[r][c];
  endfunction

  task automatic model_edge();
    int dv, dh, vr, hc, nclr;
    bit v, h, d;
    if (reset) begin
      m_state = M_LOAD; m_row = 0; m_left = 0; m_score = 0; armed = 1'b1;
      for (int r = 0; r < 12; r++) for (int c = 0; c < 16; c++) map[r][c] = 1'b0;
    end else if (armed) begin
      case (m_state)
        M_LOAD: begin
          for (int c = 0; c < 16; c++) map[m_row][c] = (m_row < BRICK_ROWS);
          if (m_row == 11) begin
            m_state = M_PLAY; m_left = BRICK_ROWS * 16; m_score = 0;
          end else m_row++;
        end
        M_PLAY: if (step) begin
          if (int'(brow) == 11) m_state = M_OVER;
          else begin
            dv = (bdir == DOWN_RIGHT || bdir == DOWN_LEFT) ? 1 : -1;
            dh = (bdir == UP_LEFT || bdir == DOWN_LEFT) ? 1 : -1;
            vr = int'(brow) + dv;
            hc = int'(bcol) + dh;
            v = brick_at(vr, int'(bcol));
            h = brick_at(int'(brow), hc);
            d = brick_at(vr, hc);
            nclr = 0;
            if (v || h) begin
              if (v) begin map[vr][int'(bcol)] = 1'b0; nclr++; end
              if (h) begin map[int'(brow)][hc] = 1'b0; nclr++; end
            end else if (d) begin
              map[vr][hc] = 1'b0; nclr++;
            end
            m_left -= nclr;
            m_score = (m_score + nclr > 255) ? 255 : m_score + nclr;
            if (m_left == 0) m_state = M_WIN;
          end
        end
        default: if (restart) begin m_state = M_LOAD; m_row = 0; end
      endcase
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.data = '0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++) e.data[r*16 + c] = map[r][c];
    for (int c = 0; c < 16; c++)
      if (c >= int'(pcol) && c < int'(pcol) + PADDLE_W) e.data[176 + c] = 1'b1;
    e.flags = {m_state != M_PLAY, m_state == M_OVER, m_state == M_WIN};
    e.left  = 8'(m_left);
`ifdef BRICK_FIELD_SCORE_EN
    e.sc    = 8'(m_score);
`else
    e.sc    = 8'd0;
`endif
    e.cyc   = cyc;
    return e;
  endfunction

  // One clock: advance the model over the edge, then drive the next inputs.
  task automatic tick(input bit st, input int r, input int c, input int d,
                      input int pc, input bit rs, input bit rst);
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    step = st; brow = 4'(r); bcol = 4'(c); bdir = 2'(d);
    pcol = 4'(pc); restart = rs; reset = rst;
    if (armed) q.push_back(snapshot());
  endtask

  // Idle cycles; steps/restarts are only injected where they must be ignored.
  task automatic idle(input int n);
    bit st, rs;
    for (int i = 0; i < n; i++) begin
      st = (m_state != M_PLAY) && ($urandom_range(0, 1) == 1);
      rs = (m_state == M_LOAD) && ($urandom_range(0, 1) == 1);
      tick(st, $urandom_range(0, 11), $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 15), rs, 1'b0);
    end
  endtask

  task automatic check(input string name, input int c, input logic [191:0] act,
                       input logic [191:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("data", e.cyc, data, e.data);
      check("flags{over,lost,won}", e.cyc, 192'({IsGameOver, game_lost, game_won}), 192'(e.flags));
      check("bricks_left", e.cyc, 192'(bricks_left), 192'(e.left));
      check("score", e.cyc, 192'(score), 192'(e.sc));
    end
  end

  initial begin
    int budget;
    tick(0, 0, 0, 0, 5, 0, 1);
    tick(0, 0, 0, 0, 5, 0, 1);
    tick(0, 0, 0, 0, 5, 0, 0);
    idle(14);

    // Directed clears: direct V hit, then diagonal-only hit.
    tick(1, 4, 5, UP_RIGHT, 3, 0, 0);
    tick(0, 0, 0, 0, 3, 0, 0);
    tick(1, 4, 5, UP_RIGHT, 3, 0, 0);
    tick(0, 0, 0, 0, 14, 0, 0);
    tick(0, 0, 0, 0, 15, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 150; i++)
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 10), $urandom_range(0, 15),
           $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1) == 1, 0);

    // Reset in the middle of play.
    tick(0, 0, 0, 0, 2, 0, 1);
    tick(0, 0, 0, 0, 2, 0, 0);
    idle(14);

    // Loss through the paddle row, frozen map, then restart.
    tick(1, 11, 0, UP_LEFT, 8, 0, 0);
    idle(4);
    tick(0, 0, 0, 0, 8, 1, 0);
    idle(14);

    // Clear every brick row by row, bottom brick row first.
    for (int r = BRICK_ROWS - 1; r >= 0; r--)
      for (int c = 0; c < 16; c++)
        tick(1, r + 1, c, UP_RIGHT, $urandom_range(0, 15), 0, 0);
    tick(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    tick(0, 0, 0, 0, 1, 1, 0);
    idle(5);

    // Reset in the middle of a load.
    tick(0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 1, 0, 0);
    idle(15);
    tick(1, 1, 7, DOWN_LEFT, 4, 0, 0);
    tick(0, 0, 0, 0, 4, 0, 0);

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    @(posedge clock);
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
